// File: rtl/metronome_fsm_if.sv
// Control/status bundle between the metronome and its host.
// The master side drives tempo and run; the slave side drives the codec voice.
interface metronome_fsm_if;
  logic        iRUN;
  logic [8:0]  iBPM;
  logic [2:0]  iBEATS;
  logic        oKEY_ON;
  logic [15:0] oSOUND;
  logic        oBEAT_PULSE;
  logic [2:0]  oBEAT_IDX;

  modport master (
    output iRUN, iBPM, iBEATS,
    input  oKEY_ON, oSOUND, oBEAT_PULSE, oBEAT_IDX
  );

  modport slave (
    input  iRUN, iBPM, iBEATS,
    output oKEY_ON, oSOUND, oBEAT_PULSE, oBEAT_IDX
  );
endinterface

// File: rtl/metronome_fsm.sv
// Tempo generator and click sequencer for codec voice 3.
// A fractional accumulator gives drift-free beats without a divider.
module metronome_fsm #(
  parameter int unsigned REF_CLK    = 18432000,
  parameter int unsigned CLICK_LEN  = 552960,
  parameter int unsigned ACCENT_INC = 2500,
  parameter int unsigned NORMAL_INC = 1250
) (
  input  logic           iCLK_18_4,
  input  logic           iRST_N,
  metronome_fsm_if.slave bus
);
  localparam logic [31:0] BEAT_MOD = 32'(REF_CLK * 60);
  localparam int unsigned CW       = (CLICK_LEN > 1) ? $clog2(CLICK_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLICK_LEN - 1);
  localparam logic [15:0] ACC_W    = 16'(ACCENT_INC);
  localparam logic [15:0] NRM_W    = 16'(NORMAL_INC);

  typedef enum logic [1:0] {S_IDLE, S_CLICK, S_GAP, S_RETRIG} state_t;

  logic          r_sync1, r_run_s;
  state_t        r_state, w_state;
  logic [30:0]   r_acc, w_acc;
  logic [8:0]    r_bpm, w_bpm;
  logic [2:0]    r_idx, w_idx;
  logic [15:0]   r_sound, w_sound;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_pulse, w_pulse;

  logic [8:0]    w_bpm_c;
  logic [31:0]   w_sum;
  logic          w_beat;
  logic [3:0]    w_n, w_idx_inc;
  logic [2:0]    w_idx_next;
  logic [15:0]   w_click_inc;

  assign w_bpm_c     = (bus.iBPM < 9'd30)  ? 9'd30  :
                       (bus.iBPM > 9'd300) ? 9'd300 : bus.iBPM;
  assign w_sum       = {1'b0, r_acc} + {23'b0, r_bpm};
  assign w_beat      = (r_state != S_IDLE) && (w_sum >= BEAT_MOD);
  assign w_n         = (bus.iBEATS == 3'd0) ? 4'd8 : {1'b0, bus.iBEATS};
  assign w_idx_inc   = {1'b0, r_idx} + 4'd1;
  // >= rather than == so a bar length shrunk below the current index still wraps.
  assign w_idx_next  = (w_idx_inc >= w_n) ? 3'd0 : w_idx_inc[2:0];
  assign w_click_inc = ((w_idx_next == 3'd0) && (bus.iBEATS != 3'd0)) ? ACC_W : NRM_W;

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sync1 <= 1'b0;
      r_run_s <= 1'b0;
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_bpm   <= '0;
      r_idx   <= '0;
      r_sound <= '0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= bus.iRUN;
      r_run_s <= r_sync1;
      r_state <= w_state;
      r_acc   <= w_acc;
      r_bpm   <= w_bpm;
      r_idx   <= w_idx;
      r_sound <= w_sound;
      r_cnt   <= w_cnt;
      r_pulse <= w_pulse;
    end
  end

  always_comb begin
    w_state = r_state;
    w_acc   = r_acc;
    w_bpm   = r_bpm;
    w_idx   = r_idx;
    w_sound = r_sound;
    w_cnt   = r_cnt;
    w_pulse = 1'b0;
    if (!r_run_s) begin
      w_state = S_IDLE;
      w_acc   = '0;
      w_idx   = '0;
      w_sound = '0;
      w_cnt   = '0;
    end else if (r_state == S_IDLE) begin
      w_state = S_CLICK;
      w_acc   = '0;
      w_bpm   = w_bpm_c;
      w_idx   = '0;
      w_sound = (bus.iBEATS != 3'd0) ? ACC_W : NRM_W;
      w_cnt   = '0;
      w_pulse = 1'b1;
    end else if (w_beat) begin
      // A beat beats counter expiry; an active click is cut via RETRIG to force a gate negedge.
      w_acc   = 31'(w_sum - BEAT_MOD);
      w_bpm   = w_bpm_c;
      w_idx   = w_idx_next;
      w_sound = w_click_inc;
      w_cnt   = '0;
      w_pulse = 1'b1;
      w_state = (r_state == S_GAP) ? S_CLICK : S_RETRIG;
    end else begin
      w_acc = w_sum[30:0];
      case (r_state)
        S_CLICK: begin
          if (r_cnt == CNT_LAST) w_state = S_GAP;
          else                   w_cnt   = r_cnt + CW'(1);
        end
        S_RETRIG: begin
          w_state = S_CLICK;
          w_cnt   = '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.oKEY_ON     = (r_state == S_CLICK);
  assign bus.oSOUND      = r_sound;
  assign bus.oBEAT_PULSE = r_pulse;
  assign bus.oBEAT_IDX   = r_idx;
endmodule

// File: tb/tb_metronome_fsm.sv
// Bench for metronome_fsm: two instances (short and long click) driven together,
// checked each cycle against a beat-time model derived from tempo arithmetic.
module tb_metronome_fsm;
  localparam int unsigned REF  = 1000;
  localparam int unsigned MOD  = REF * 60;
  localparam int unsigned LENA = 50;
  localparam int unsigned LENB = 600;
  localparam logic [15:0] ACC  = 16'd2500;
  localparam logic [15:0] NRM  = 16'd1250;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        run   = 1'b0;
  logic [8:0]  bpm   = 9'd120;
  logic [2:0]  beats = 3'd4;
  int unsigned cyc   = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  metronome_fsm_if ifa();
  metronome_fsm_if ifb();
  assign ifa.iRUN = run;  assign ifa.iBPM = bpm;  assign ifa.iBEATS = beats;
  assign ifb.iRUN = run;  assign ifb.iBPM = bpm;  assign ifb.iBEATS = beats;

  metronome_fsm #(.REF_CLK(REF), .CLICK_LEN(LENA)) dut_a (
    .iCLK_18_4(clk), .iRST_N(rst_n), .bus(ifa));
  metronome_fsm #(.REF_CLK(REF), .CLICK_LEN(LENB)) dut_b (
    .iCLK_18_4(clk), .iRST_N(rst_n), .bus(ifb));

  // Observed {pulse, idx, sound, key}
  logic [20:0] o_a, o_b;
  assign o_a = {ifa.oBEAT_PULSE, ifa.oBEAT_IDX, ifa.oSOUND, ifa.oKEY_ON};
  assign o_b = {ifb.oBEAT_PULSE, ifb.oBEAT_IDX, ifb.oSOUND, ifb.oKEY_ON};

  // Reference model state
  bit          p1, p2, m_act, e_pulse;
  int unsigned m_next, m_rem, m_b, sA, sB;
  int          m_idx;
  logic [15:0] m_snd;
  logic [20:0] e_a, e_b;

  function automatic int unsigned clampb(input logic [8:0] v);
    if (v < 9'd30)  return 30;
    if (v > 9'd300) return 300;
    return int'(v);
  endfunction

  task automatic schedule(input int unsigned t);
    int unsigned j;
    m_b    = clampb(bpm);
    j      = (MOD - m_rem + m_b - 1) / m_b;
    m_next = t + j;
    m_rem  = m_rem + j * m_b - MOD;
  endtask

  task automatic model_reset();
    p1 = 0; p2 = 0; m_act = 0; e_pulse = 0;
    e_a = '0; e_b = '0;
  endtask

  // Advance one cycle and compute expected outputs (sampled at negedge).
  task automatic step();
    int unsigned t;
    bit fr;
    int n;
    bit ka, kb;
    @(negedge clk);
    t = cyc;
    fr = p2; p2 = p1; p1 = run;
    e_pulse = 0;
    if (!fr) begin
      m_act = 0;
    end else if (!m_act) begin
      m_act = 1; m_idx = 0; m_rem = 0;
      schedule(t);
      sA = t; sB = t;
      m_snd = (beats != 0) ? ACC : NRM;
      e_pulse = 1;
    end else if (t == m_next) begin
      n = (beats == 0) ? 8 : int'(beats);
      m_idx = (m_idx + 1 >= n) ? 0 : m_idx + 1;
      m_snd = (m_idx == 0 && beats != 0) ? ACC : NRM;
      sA = (t <= sA + LENA) ? t + 1 : t;
      sB = (t <= sB + LENB) ? t + 1 : t;
      schedule(t);
      e_pulse = 1;
    end
    ka = m_act && (t >= sA) && (t < sA + LENA);
    kb = m_act && (t >= sB) && (t < sB + LENB);
    e_a = {e_pulse, m_act ? 3'(m_idx) : 3'd0, m_act ? m_snd : 16'd0, ka};
    e_b = {e_pulse, m_act ? 3'(m_idx) : 3'd0, m_act ? m_snd : 16'd0, kb};
  endtask

  task automatic stop_idle();
    run = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0;
    repeat (3) @(negedge clk);
    n_tests += 2;
    if (o_a !== 21'd0) begin n_fail++; $display("FAIL reset_a got %h want 0", o_a); end
    if (o_b !== 21'd0) begin n_fail++; $display("FAIL reset_b got %h want 0", o_b); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    bpm = 9'd120; beats = 3'd4; run = 1'b1;
    for (int i = 0; i < 2600; i++) begin
      step();
      n_tests += 2;
      if (o_a !== e_a) begin n_fail++; $display("FAIL basic_a cyc=%0d got %h want %h", cyc, o_a, e_a); end
      if (o_b !== e_b) begin n_fail++; $display("FAIL basic_b cyc=%0d got %h want %h", cyc, o_b, e_b); end
      if (i == 2 || i == 502) begin
        n_tests++;
        if ({ifa.oBEAT_PULSE, ifa.oKEY_ON, ifa.oBEAT_IDX, ifa.oSOUND} !==
            {1'b1, 1'b1, (i == 2) ? 3'd0 : 3'd1, (i == 2) ? ACC : NRM}) begin
          n_fail++;
          $display("FAIL basic_beat i=%0d got p=%b k=%b idx=%0d snd=%0d", i,
                   ifa.oBEAT_PULSE, ifa.oKEY_ON, ifa.oBEAT_IDX, ifa.oSOUND);
        end
      end
    end
  endtask

  task automatic test_tempo_change();
    stop_idle();
    bpm = 9'd10; beats = 3'($urandom_range(1, 7)); run = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      step();
      n_tests += 2;
      if (o_a !== e_a) begin n_fail++; $display("FAIL tempo_a cyc=%0d got %h want %h", cyc, o_a, e_a); end
      if (o_b !== e_b) begin n_fail++; $display("FAIL tempo_b cyc=%0d got %h want %h", cyc, o_b, e_b); end
      if (i == 2002 || i == 4002 || i == 4202 || i == 4402) begin
        n_tests++;
        if (ifa.oBEAT_PULSE !== 1'b1) begin
          n_fail++; $display("FAIL tempo_pulse i=%0d got %b want 1", i, ifa.oBEAT_PULSE);
        end
      end
      if (i == 3000) bpm = 9'd400;
    end
  endtask

  task automatic test_beats0();
    stop_idle();
    beats = 3'd0; bpm = 9'd300; run = 1'b1;
    for (int i = 0; i < 2200; i++) begin
      step();
      n_tests += 2;
      if (o_a !== e_a) begin n_fail++; $display("FAIL beats0_a cyc=%0d got %h want %h", cyc, o_a, e_a); end
      if (o_b !== e_b) begin n_fail++; $display("FAIL beats0_b cyc=%0d got %h want %h", cyc, o_b, e_b); end
      if (ifa.oBEAT_PULSE === 1'b1) begin
        n_tests++;
        if (ifa.oSOUND !== NRM) begin
          n_fail++; $display("FAIL beats0_snd cyc=%0d got %0d want %0d", cyc, ifa.oSOUND, NRM);
        end
      end
    end
  endtask

  task automatic test_retrig();
    int hi, max_hi;
    hi = 0; max_hi = 0;
    stop_idle();
    bpm = 9'd120; beats = 3'd2; run = 1'b1;
    for (int i = 0; i < 2200; i++) begin
      step();
      n_tests++;
      if (o_b !== e_b) begin n_fail++; $display("FAIL retrig_b cyc=%0d got %h want %h", cyc, o_b, e_b); end
      hi = (ifb.oKEY_ON === 1'b1) ? hi + 1 : 0;
      if (hi > max_hi) max_hi = hi;
      if (i == 502 || i == 503) begin
        n_tests++;
        if (ifb.oKEY_ON !== ((i == 503) ? 1'b1 : 1'b0)) begin
          n_fail++; $display("FAIL retrig_gap i=%0d got %b", i, ifb.oKEY_ON);
        end
      end
    end
    n_tests++;
    if (max_hi > 500) begin n_fail++; $display("FAIL retrig_maxlen got %0d want <=500", max_hi); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      stop_idle();
      bpm = 9'($urandom_range(0, 511)); beats = 3'($urandom_range(0, 7)); run = 1'b1;
      for (int i = 0; i < 2400; i++) begin
        step();
        n_tests += 2;
        if (o_a !== e_a) begin n_fail++; $display("FAIL rand_a cyc=%0d got %h want %h", cyc, o_a, e_a); end
        if (o_b !== e_b) begin n_fail++; $display("FAIL rand_b cyc=%0d got %h want %h", cyc, o_b, e_b); end
        if (i == 1200) begin
          bpm = 9'($urandom_range(0, 511)); beats = 3'($urandom_range(0, 7));
        end
      end
    end
  endtask

  task automatic test_stop_restart();
    int seen;
    seen = 0;
    stop_idle();
    bpm = 9'($urandom_range(150, 300)); beats = 3'd3; run = 1'b1;
    for (int i = 0; i < 3000 && seen < 2; i++) begin
      step();
      n_tests++;
      if (o_a !== e_a) begin n_fail++; $display("FAIL stop_a cyc=%0d got %h want %h", cyc, o_a, e_a); end
      if (e_pulse) seen++;
    end
    n_tests++;
    if (seen < 2) begin n_fail++; $display("FAIL stop_wait got %0d beats want 2", seen); end
    repeat (10) step();
    run = 1'b0;
    repeat (3) step();
    n_tests += 2;
    if (ifa.oKEY_ON !== 1'b0) begin n_fail++; $display("FAIL stop_key_a got %b want 0", ifa.oKEY_ON); end
    if (o_a !== e_a) begin n_fail++; $display("FAIL stop_idle_a got %h want %h", o_a, e_a); end
    repeat (20) step();
    run = 1'b1;
    for (int i = 0; i < 700; i++) begin
      step();
      n_tests += 2;
      if (o_a !== e_a) begin n_fail++; $display("FAIL restart_a cyc=%0d got %h want %h", cyc, o_a, e_a); end
      if (o_b !== e_b) begin n_fail++; $display("FAIL restart_b cyc=%0d got %h want %h", cyc, o_b, e_b); end
      if (i == 2) begin
        n_tests++;
        if ({ifa.oBEAT_PULSE, ifa.oBEAT_IDX, ifa.oSOUND} !== {1'b1, 3'd0, ACC}) begin
          n_fail++; $display("FAIL restart_accent got p=%b idx=%0d snd=%0d want 1 0 %0d",
                             ifa.oBEAT_PULSE, ifa.oBEAT_IDX, ifa.oSOUND, ACC);
        end
      end
    end
  endtask

  task automatic test_reset_midclick();
    bit got;
    got = 0;
    stop_idle();
    bpm = 9'd200; beats = 3'd5; run = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (e_pulse) got = 1;
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL rstmid_wait got no start want start"); end
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1;
    n_tests += 2;
    if (o_a !== 21'd0) begin n_fail++; $display("FAIL rstmid_a got %h want 0", o_a); end
    if (o_b !== 21'd0) begin n_fail++; $display("FAIL rstmid_b got %h want 0", o_b); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 700; i++) begin
      step();
      n_tests += 2;
      if (o_a !== e_a) begin n_fail++; $display("FAIL rstrun_a cyc=%0d got %h want %h", cyc, o_a, e_a); end
      if (o_b !== e_b) begin n_fail++; $display("FAIL rstrun_b cyc=%0d got %h want %h", cyc, o_b, e_b); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_tempo_change();
    test_beats0();
    test_retrig();
    test_random();
    test_stop_restart();
    test_reset_midclick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/metronome_fsm.md
# metronome_fsm

Tempo generator and click sequencer driving the codec's third voice channel (`key3_on` / `sound3`, the square-wave timbre). From a BPM setting and a beats-per-bar setting, it produces a gated click envelope and a phase increment for the codec's ramp. Beat 0 of each bar gets an accented pitch. Beat timing is exact to the 18.432 MHz reference because it uses a fractional accumulator with no divider.

## Interface
- REF_CLK, 18432000, reference clock in Hz; BEAT_MOD = REF_CLK*60 (31-bit)
- CLICK_LEN, 552960, click gate length in clock cycles (30 ms)
- ACCENT_INC, 2500, phase increment for the beat-0 click (~2 kHz at 48 kHz LRCK)
- NORMAL_INC, 1250, phase increment for the other beats (~1 kHz)
- iCLK_18_4  in  1  system clock, 18.432 MHz
- iRST_N  in  1  reset, asynchronous, active-low
- iRUN  in  1  metronome enable, asynchronous switch, synchronized internally
- iBPM  in  9  tempo in beats/min, clamped to [30,300], quasi-static
- iBEATS  in  3  beats per bar 1..7; 0 = 8 beats with no accent
- oKEY_ON  out  1  click gate, connects to codec key3_on
- oSOUND  out  16  phase increment, connects to codec sound3
- oBEAT_PULSE  out  1  one-cycle strobe at each beat start
- oBEAT_IDX  out  3  index of the current beat within the bar

## Operation
- iRUN passes through a 2-flop synchronizer giving run_s. All other logic uses run_s.
- Tempo: bpm_c = clamp(iBPM, 30, 300), latched at start and at every beat event.
- Accumulator: 31-bit acc. Each running cycle:
  - if acc + bpm_c >= BEAT_MOD, raise a beat event and set acc <= acc + bpm_c - BEAT_MOD;
  - otherwise set acc <= acc + bpm_c.
  - Mean beat period is exactly BEAT_MOD/bpm_c cycles, with no drift.
- Beat index:
  - Let N = iBEATS, or 8 when iBEATS = 0.
  - On each beat event after start: idx <= (idx+1 >= N) ? 0 : idx+1.
  - If iBEATS shrinks below idx+1, the index wraps to 0 at the next beat.
- Pitch: at click start, oSOUND <= ACCENT_INC if idx_next == 0 and iBEATS != 0, else NORMAL_INC. oSOUND holds that value until the next click start.
- FSM states:
  - IDLE: acc = 0, idx = 0, outputs 0. On run_s = 1, go to CLICK as beat 0 (start event).
  - CLICK: oKEY_ON = 1. The click counter counts up to CLICK_LEN-1, then the FSM goes to GAP. A beat event in CLICK goes to RETRIG.
  - GAP: oKEY_ON = 0. A beat event goes to CLICK with the counter cleared.
  - RETRIG: oKEY_ON = 0 for exactly 1 cycle, then CLICK with the counter cleared. This forces a negedge so the codec ramp restarts.
  - From any state, run_s = 0 goes to IDLE.
- oBEAT_PULSE is asserted on the start event and on every beat event.

## Timing
- Reset values: oKEY_ON = 0, oSOUND = 0, oBEAT_PULSE = 0, oBEAT_IDX = 0, acc = 0, FSM in IDLE. Reset is legal at any time and aborts an in-progress click immediately.
- Start latency: iRUN is sampled high at edge k. oKEY_ON = 1, oBEAT_PULSE = 1 and oSOUND = ACCENT_INC are all visible after edge k+2.
- Beat event timing: the event is detected combinationally. FSM state, oBEAT_PULSE, oBEAT_IDX and oSOUND update on the same edge.
- Inter-beat spacing from the start event is exactly ceil-accumulated BEAT_MOD/bpm_c cycles. At 120 BPM with the default REF_CLK, the first beat comes 9,216,000 cycles after start.
- oKEY_ON stays high exactly CLICK_LEN cycles per click, unless a retrigger or a stop cuts it short.
- Beat event on the same cycle as click-counter expiry: the beat wins and the FSM goes to RETRIG.
- Stop: iRUN sampled low at edge k gives oKEY_ON = 0 and IDLE after edge k+2. A restart always begins at beat 0 with acc = 0.
- iBPM changes take effect only at the next beat event, never mid-interval.

## Test plan
- REF_CLK=1000, CLICK_LEN=50, iBPM=120, iBEATS=4, raise iRUN. Required: oBEAT_PULSE 2 cycles after the sample edge, then every 500 cycles. oBEAT_IDX sequence 0,1,2,3,0. oSOUND = 2500 only on idx 0, 1250 otherwise. oKEY_ON high for exactly 50 cycles per beat.
- iBPM=10, then iBPM=400 (REF_CLK=1000). Required: beat periods of 2000 cycles, then 200 cycles, switching at the first beat after each change.
- CLICK_LEN=600, iBPM=120, REF_CLK=1000. Required: at each beat, oKEY_ON low for exactly 1 cycle, then high again. No click ever lasts longer than 500 cycles.
- iBEATS=0. Required: idx cycles 0..7 and oSOUND is always 1250.
- Drop iRUN mid-click. Required: oKEY_ON = 0 within 2 cycles. On restart, the first pulse is accented with idx 0. Assert iRST_N low mid-click: all outputs go to 0 asynchronously.
- iBPM=100 with default REF_CLK. Required: beat spacing exactly 11,059,200 cycles across 3 beats, with no drift.
